// File: rtl/rop3_pkg.sv
// Shared types and constants for the ROP3 engine slot scheduler.
// Tag ids are sized for the largest supported requester count (4).
package rop3_pkg;

  localparam int NREQ_MAX = 4;
  localparam int ID_W     = $clog2(NREQ_MAX);

  // Slot phase, named after the operand the engine sees on Bitmap in that cycle.
  typedef enum logic [1:0] {
    PH_P = 2'd0,
    PH_S = 2'd1,
    PH_D = 2'd2
  } phase_t;

  typedef struct packed {
    logic            busy;
    logic [ID_W-1:0] id;
  } tag_t;

  localparam logic [7:0] ROP_BLACKNESS  = 8'h00;
  localparam logic [7:0] ROP_PATINVERT  = 8'h5A;
  localparam logic [7:0] ROP_SRCINVERT  = 8'h66;
  localparam logic [7:0] ROP_SRCAND     = 8'h88;
  localparam logic [7:0] ROP_MERGECOPY  = 8'hC0;
  localparam logic [7:0] ROP_SRCCOPY    = 8'hCC;
  localparam logic [7:0] ROP_PATCOPY    = 8'hF0;
  localparam logic [7:0] ROP_WHITENESS  = 8'hFF;

  function automatic int rr_idx(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/rop3_tag_fifo.sv
// Small synchronous FIFO holding one slot tag per engine slot, in issue order.
// The head is read combinationally so the pop edge can act on it directly.
module rop3_tag_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A pop frees a slot in the same cycle, so push-on-full is fine when popping.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rop3_sched.sv
// Shares one phase-locked ROP3 engine among NREQ requesters: round-robin grant
// once per 3-cycle slot, P/S/D serialised onto Bitmap, results routed by tag.
module rop3_sched
  import rop3_pkg::*;
#(
  parameter int N         = 8,
  parameter int NREQ      = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [8*NREQ-1:0]     req_mode,
  input  logic [3*N*NREQ-1:0]   req_psd,
  output logic [NREQ-1:0]       resp_valid,
  output logic [N-1:0]          resp_result,
  output logic                  eng_srst_n,
  output logic [7:0]            eng_mode,
  output logic [N-1:0]          eng_bitmap,
  input  logic                  eng_valid,
  input  logic [N-1:0]          eng_result,
  output logic                  err
);

  localparam int CW = $clog2(TAG_DEPTH + 1);

  phase_t          phase_reg;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [N-1:0]    s_reg, d_reg;

  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic [7:0]      sel_mode;
  logic [3*N-1:0]  sel_psd;
  int              cand;
  logic            arb_en;

  tag_t            push_tag, head_tag;
  logic            tag_push, tag_full, tag_empty;
  logic [CW-1:0]   tag_count;

  // Engine reset tracks ours cycle-for-cycle so its phase stays aligned.
  assign eng_srst_n = ~srst;
  assign arb_en     = !srst && (phase_reg == PH_D);

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    sel_mode  = '0;
    sel_psd   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_idx(int'(rr_ptr_reg), k, NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(cand);
        sel_mode  = req_mode[8*cand +: 8];
        sel_psd   = req_psd[3*N*cand +: 3*N];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = arb_en && grant_any && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Every slot gets a tag, empty ones included, so tags and engine results pair up in order.
  always_comb begin
    push_tag      = '0;
    push_tag.busy = grant_any;
    push_tag.id   = grant_id;
  end
  assign tag_push = arb_en;

  rop3_tag_fifo #(
    .WIDTH ($bits(tag_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .srst      (srst),
    .push      (tag_push),
    .push_data (push_tag),
    .pop       (eng_valid),
    .pop_data  (head_tag),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      phase_reg   <= PH_P;
      rr_ptr_reg  <= '0;
      eng_mode    <= '0;
      eng_bitmap  <= '0;
      s_reg       <= '0;
      d_reg       <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      err         <= 1'b0;
    end else begin
      case (phase_reg)
        PH_D: begin
          phase_reg <= PH_P;
          if (grant_any) begin
            eng_mode   <= sel_mode;
            eng_bitmap <= sel_psd[3*N-1:2*N];
            s_reg      <= sel_psd[2*N-1:N];
            d_reg      <= sel_psd[N-1:0];
            rr_ptr_reg <= ID_W'(rr_idx(int'(grant_id), 1, NREQ));
          end else begin
            eng_bitmap <= '0;
            s_reg      <= '0;
            d_reg      <= '0;
          end
        end
        PH_P: begin
          phase_reg  <= PH_S;
          eng_bitmap <= s_reg;
        end
        PH_S: begin
          phase_reg  <= PH_D;
          eng_bitmap <= d_reg;
        end
        default: phase_reg <= PH_P;
      endcase

      resp_valid <= '0;
      if (eng_valid && (tag_count != '0) && head_tag.busy) begin
        resp_valid  <= NREQ'(1) << head_tag.id;
        resp_result <= eng_result;
      end

      if ((tag_push && tag_full && !eng_valid) || (eng_valid && tag_empty))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rop3_sched.sv
// Randomised bench for rop3_sched with a behavioural ROP3 engine and a
// transaction-level model of grants and responses.
module tb_rop3_sched;

  localparam int N         = 8;
  localparam int NREQ      = 2;
  localparam int TAG_DEPTH = 4;

  logic                clk = 1'b0;
  logic                srst = 1'b1;
  logic [NREQ-1:0]     req_valid, req_ready, resp_valid;
  logic [8*NREQ-1:0]   req_mode;
  logic [3*N*NREQ-1:0] req_psd;
  logic [N-1:0]        resp_result, eng_bitmap, eng_result;
  logic [7:0]          eng_mode;
  logic                eng_srst_n, eng_valid, err;
  logic                e_valid, force_ev;

  assign eng_valid = e_valid | force_ev;

  always #5 clk = ~clk;

  rop3_sched #(.N(N), .NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk         (clk),
    .srst        (srst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mode    (req_mode),
    .req_psd     (req_psd),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .eng_srst_n  (eng_srst_n),
    .eng_mode    (eng_mode),
    .eng_bitmap  (eng_bitmap),
    .eng_valid   (eng_valid),
    .eng_result  (eng_result),
    .err         (err)
  );

  function automatic logic [N-1:0] rop(input logic [7:0] m, input logic [N-1:0] p,
                                       input logic [N-1:0] s, input logic [N-1:0] d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m[{p[i], s[i], d[i]}];
    return r;
  endfunction

  // Engine: samples P,S,D in its own phases 0,1,2; the first slot after reset is warm-up.
  int          e_ph;
  logic        e_armed;
  logic [N-1:0] e_p, e_s;
  always @(posedge clk) begin
    if (!eng_srst_n) begin
      e_ph <= 0; e_armed <= 1'b0; e_valid <= 1'b0; eng_result <= '0;
    end else begin
      e_valid <= 1'b0;
      case (e_ph)
        0: e_p <= eng_bitmap;
        1: e_s <= eng_bitmap;
        default: begin
          eng_result <= rop(eng_mode, e_p, e_s, eng_bitmap);
          e_valid    <= e_armed;
          e_armed    <= 1'b1;
        end
      endcase
      e_ph <= (e_ph == 2) ? 0 : e_ph + 1;
    end
  end

  int cyc, tick;
  always @(posedge clk) begin
    tick <= tick + 1;
    cyc  <= srst ? 0 : cyc + 1;
  end

  typedef struct { int id; logic [N-1:0] res; int due; } exp_t;
  exp_t q[$];

  logic         m_v [NREQ];
  logic [7:0]   m_mode [NREQ];
  logic [N-1:0] m_p [NREQ], m_s [NREQ], m_d [NREQ];
  int           rr, auto_mode, checks, fails, accepts;
  logic         exp_err;
  logic [NREQ-1:0] last_rv;
  logic [N-1:0] last_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @tick %0d: got %0h expected %0h", tag, tick, got, want);
    end
  endtask

  task automatic apply();
    for (int r = 0; r < NREQ; r++) begin
      req_valid[r]             = m_v[r];
      req_mode[8*r +: 8]       = m_mode[r];
      req_psd[3*N*r +: 3*N]    = {m_p[r], m_s[r], m_d[r]};
    end
  endtask

  task automatic set_req(input int r, input logic [7:0] m, input logic [N-1:0] p,
                         input logic [N-1:0] s, input logic [N-1:0] d);
    m_v[r] = 1'b1; m_mode[r] = m; m_p[r] = p; m_s[r] = s; m_d[r] = d;
  endtask

  task automatic rand_req(input int r);
    set_req(r, 8'($urandom), N'($urandom), N'($urandom), N'($urandom));
  endtask

  // One cycle: check at negedge against the model, then update stimulus after posedge.
  task automatic step();
    int w;
    logic [NREQ-1:0] want_ready, want_rv;
    exp_t e;
    @(negedge clk);
    w = -1;
    want_ready = '0;
    if (!srst && (cyc % 3 == 2))
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && m_v[(rr + k) % NREQ]) w = (rr + k) % NREQ;
    if (w >= 0) want_ready[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(want_ready));
    if (w >= 0) begin
      e.id = w; e.res = rop(m_mode[w], m_p[w], m_s[w], m_d[w]); e.due = tick + 5;
      q.push_back(e);
      rr = (w + 1) % NREQ;
      accepts++;
      $display("tick %0d: grant req%0d mode %02h psd %02h/%02h/%02h", tick, w,
               m_mode[w], m_p[w], m_s[w], m_d[w]);
    end
    if (srst) begin
      q.delete();
      rr = 0;
      exp_err = 1'b0;
    end else begin
      want_rv = '0;
      if (resp_valid != '0) begin
        last_rv = resp_valid;
        last_res = resp_result;
      end
      if (q.size() > 0 && q[0].due == tick) begin
        e = q.pop_front();
        want_rv[e.id] = 1'b1;
        check("resp_valid", 32'(resp_valid), 32'(want_rv));
        check("resp_result", 32'(resp_result), 32'(e.res));
        $display("tick %0d: resp req%0d result %02h (expect %02h)", tick, e.id, resp_result, e.res);
      end else begin
        check("resp_idle", 32'(resp_valid), 32'(want_rv));
      end
      check("err", 32'(err), 32'(exp_err));
    end
    @(posedge clk);
    #1;
    if (w >= 0) begin
      if (auto_mode != 0) rand_req(w);
      else m_v[w] = 1'b0;
    end
    if (auto_mode == 2)
      for (int r = 0; r < NREQ; r++)
        if (!m_v[r] && $urandom_range(0, 3) == 0) rand_req(r);
    apply();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < max_cycles) begin
      step();
      n++;
      busy = (q.size() > 0);
      for (int r = 0; r < NREQ; r++) if (m_v[r]) busy = 1'b1;
    end
    if (busy) check("drain_timeout", 32'(n), 32'(max_cycles + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; fails = 0; rr = 0; auto_mode = 0; accepts = 0;
    exp_err = 1'b0; force_ev = 1'b0;
    req_valid = '0; req_mode = '0; req_psd = '0;
    for (int r = 0; r < NREQ; r++) begin
      m_v[r] = 1'b0; m_mode[r] = '0; m_p[r] = '0; m_s[r] = '0; m_d[r] = '0;
    end
    apply();
    repeat (3) @(posedge clk);
    #1;
    set_req(0, 8'hCC, 8'hAA, 8'h55, 8'h0F);
    apply();

    // Reset state, with a request pending so ready really has something to refuse.
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_result", 32'(resp_result), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_bitmap", 32'(eng_bitmap), 32'h0);
    check("rst_mode", 32'(eng_mode), 32'h0);
    check("rst_eng_srst_n", 32'(eng_srst_n), 32'h0);
    @(posedge clk);
    #1;
    m_v[0] = 1'b0;
    apply();

    // Pop on empty FIFO right after reset.
    srst = 1'b0;
    force_ev = 1'b1;
    step();
    force_ev = 1'b0;
    exp_err = 1'b1;
    repeat (4) step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    step();
    check("err_cleared", 32'(err), 32'h0);

    // Single request from req0.
    last_rv = '0; last_res = '0;
    set_req(0, 8'hC0, 8'hF0, 8'h3C, 8'h00);
    apply();
    run_until_idle(40);
    check("t1_resp_valid", 32'(last_rv), 32'h1);
    check("t1_result", 32'(last_res), 32'h30);

    // Both requesters held busy: grants must alternate.
    auto_mode = 1;
    rand_req(0); rand_req(1);
    apply();
    repeat (30) step();
    auto_mode = 0;
    run_until_idle(60);

    // req1 alone.
    last_rv = '0; last_res = '0;
    set_req(1, 8'h5A, 8'hFF, 8'h00, 8'h0F);
    apply();
    run_until_idle(40);
    check("t3_resp_valid", 32'(last_rv), 32'h2);
    check("t3_result", 32'(last_res), 32'hF0);

    // Idle slots: bitmap stays zero, no responses, no error.
    repeat (30) begin
      step();
      check("idle_bitmap", 32'(eng_bitmap), 32'h0);
    end

    // Reset with two slots in flight, then one fresh request.
    rand_req(0); rand_req(1);
    apply();
    accepts = 0;
    for (int n = 0; n < 20 && accepts < 2; n++) step();
    check("t5_two_accepts", 32'(accepts), 32'd2);
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    repeat (9) step();
    last_rv = '0; last_res = '0;
    set_req(0, 8'h88, 8'h00, 8'hF3, 8'h5C);
    apply();
    run_until_idle(40);
    check("t5_resp_valid", 32'(last_rv), 32'h1);
    check("t5_result", 32'(last_res), 32'h50);

    // Random traffic.
    auto_mode = 2;
    repeat (300) step();
    auto_mode = 0;
    run_until_idle(80);
    check("final_err", 32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
